// File: rtl/serial_ripple_borrow_sub.sv
// Bit-serial subtractor: out = in1 - in2 - bin, one difference/borrow stage per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_ripple_borrow_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             borrow_ff;

    logic             d_c;
    logic             borrow_next_c;
    logic             last_c;
    logic [WIDTH-1:0] acc_next_c;

    // Shared full-subtractor cell operating on the current LSBs
    assign d_c           = a[0] ^ b[0] ^ borrow_ff;
    assign borrow_next_c = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow_ff);
    assign last_c        = (cnt == CW'(WIDTH - 1));
    assign acc_next_c    = {d_c, acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            acc       <= '0;
            cnt       <= '0;
            borrow_ff <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
            bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new request exactly like IDLE for back-to-back ops
                IDLE, DONE: begin
                    if (start) begin
                        a         <= in1;
                        b         <= in2;
                        borrow_ff <= bin;
                        cnt       <= '0;
                        acc       <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    acc       <= acc_next_c;
                    a         <= a >> 1;
                    b         <= b >> 1;
                    borrow_ff <= borrow_next_c;
                    cnt       <= cnt + CW'(1);
                    if (last_c) begin
                        out   <= acc_next_c;
                        bout  <= borrow_next_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit a[0]/b[0] hold the latched operand MSBs
                        ovf   <= (a[0] != b[0]) & (d_c != a[0]);
`endif
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_borrow_sub.sv
// Scoreboard bench for serial_ripple_borrow_sub: directed ops, expected results queued, monitor checks on done.
module tb_serial_ripple_borrow_sub;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             bout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    exp_t q[$];
    int   tests;
    int   fails;

    serial_ripple_borrow_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for one edge; expected result queued only when it should complete
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                         input bit expect_it, input logic [WIDTH-1:0] eo, input logic eb, input logic ev);
        exp_t e;
        in1   = x;
        in2   = y;
        bin   = c;
        start = 1'b1;
        if (expect_it) begin
            e.out  = eo;
            e.bout = eb;
            e.ovf  = ev;
            q.push_back(e);
        end
        step();
        start = 1'b0;
        in1   = 8'hC3;
        in2   = 8'h3C;
        bin   = 1'b1;
    endtask

    // Bounded wait for done; checks latency, busy held, and out frozen until completion
    task automatic wait_done(input string tag, input int exp_n);
        int         n;
        bit         busy_ok;
        bit         stable;
        logic [7:0] o0;
        n       = 0;
        busy_ok = 1'b1;
        stable  = 1'b1;
        o0      = out;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (out !== o0) stable = 1'b0;
            step();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(exp_n));
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, "_out_stable"}, 32'(stable), 32'd1);
    endtask

    // Monitor: pop and compare whenever the DUT signals completion
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            check("busy_done_exclusive", 32'(busy), 32'd0);
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out", 32'(out), 32'(e.out));
                check("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        int  seen;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        bin   = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: basic subtraction, latency WIDTH edges to done
        issue(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        wait_done("t1", WIDTH);
        step();
        check("t1_done_one_cycle", 32'(done), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // 2: unsigned wrap
        issue(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        wait_done("t2", WIDTH);
        step();

        // 3: signed overflow, then borrow-in consumed exactly
        issue(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
        wait_done("t3a", WIDTH);
        step();
        issue(8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        wait_done("t3b", WIDTH);
        step();

        // 4: start pulsed during SHIFT is ignored
        issue(8'h09, 8'h04, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
        step();
        step();
        step();
        in1   = 8'hAA;
        in2   = 8'h55;
        bin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t4", WIDTH - 4);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("t4_no_second_op", 32'(seen), 32'd0);

        // 5: back-to-back start in the DONE cycle
        issue(8'h40, 8'h01, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0);
        wait_done("t5a", WIDTH);
        issue(8'h20, 8'h21, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        check("t5_no_idle_gap", 32'(busy), 32'd1);
        wait_done("t5b", WIDTH);
        step();

        // 6: asynchronous reset mid-operation discards the op
        issue(8'h77, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_done", 32'(done), 32'd0);
        check("t6_async_out", 32'(out), 32'd0);
        check("t6_async_bout", 32'(bout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1) seen++;
        end
        check("t6_no_done_after_reset", 32'(seen), 32'd0);
        issue(8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        wait_done("t6", WIDTH);
        step();
        step();
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
